// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: WIDTH add/shift iterations on magnitudes, then one
// sign-fix cycle, giving a constant WIDTH+1 cycle accept-to-result latency.
module seq_shift_add_multiplier #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;

  logic                 accept;
  logic                 mode_s;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       sum;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready only in IDLE (and never under reset); out_valid is held in DONE
  // with product stable until out_ready is seen.
  assign accept = in_valid & in_ready;

  assign mode_s = is_signed & (SIGNED_EN != 0);
  // Magnitude of the most negative value wraps to 2^(W-1), which fits unsigned.
  assign a_abs  = (mode_s & multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign b_abs  = (mode_s & multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? mcand_q : {WIDTH{1'b0}})};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready    = (state_q == IDLE) & ~rst;
    out_valid   = (state_q == DONE);
    busy        = (state_q == RUN) | (state_q == FIX);
    product     = p_q;
    dbg_state_o = state_q;
  end

  // Datapath next-state
  always_comb begin
    p_d     = p_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d = a_abs;
          p_d     = {{WIDTH{1'b0}}, b_abs};
          neg_d   = mode_s & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          count_d = '0;
        end
      end
      RUN: begin
        p_d     = {sum, p_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
      end
      FIX: begin
        if (neg_q) p_d = ~p_q + (2*WIDTH)'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      p_q     <= p_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: three instances (32-bit signed-capable, 8-bit
// signed-capable, 8-bit unsigned-only) fed directed vectors with hand-computed products.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total_checks = 0;
  int passed_checks = 0;

  // 32-bit, SIGNED_EN=1
  logic        in_valid32 = 0, is_signed32 = 0, out_ready32 = 1;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, busy32;
  logic [63:0] product32;
  logic [1:0]  st32;

  // 8-bit, SIGNED_EN=1
  logic        in_valid8 = 0, is_signed8 = 0, out_ready8 = 1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] product8;
  logic [1:0]  st8;

  // 8-bit, SIGNED_EN=0
  logic        in_valid8u = 0, is_signed8u = 0, out_ready8u = 1;
  logic [7:0]  a8u = '0, b8u = '0;
  logic        in_ready8u, out_valid8u, busy8u;
  logic [15:0] product8u;
  logic [1:0]  st8u;

  logic [63:0] exp32_q[$];
  logic [15:0] exp8_q[$];
  logic [15:0] exp8u_q[$];

  seq_shift_add_multiplier #(.WIDTH(32), .SIGNED_EN(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .is_signed(is_signed32), .multiplicand(a32), .multiplier(b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .product(product32),
    .busy(busy32), .dbg_state_o(st32)
  );

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .is_signed(is_signed8), .multiplicand(a8), .multiplier(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8),
    .busy(busy8), .dbg_state_o(st8)
  );

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(0)) dut8u (
    .clk(clk), .rst(rst), .in_valid(in_valid8u), .in_ready(in_ready8u),
    .is_signed(is_signed8u), .multiplicand(a8u), .multiplier(b8u),
    .out_valid(out_valid8u), .out_ready(out_ready8u), .product(product8u),
    .busy(busy8u), .dbg_state_o(st8u)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else passed_checks++;
  endtask

  // Monitors: pop the expected product whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst && out_valid32 && out_ready32) begin
      if (exp32_q.size() == 0) check("dut32 unexpected result", product32, 64'hx);
      else check("dut32 product", product32, exp32_q.pop_front());
    end
    if (!rst && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) check("dut8 unexpected result", {48'h0, product8}, 64'hx);
      else check("dut8 product", {48'h0, product8}, {48'h0, exp8_q.pop_front()});
    end
    if (!rst && out_valid8u && out_ready8u) begin
      if (exp8u_q.size() == 0) check("dut8u unexpected result", {48'h0, product8u}, 64'hx);
      else check("dut8u product", {48'h0, product8u}, {48'h0, exp8u_q.pop_front()});
    end
  end

  // Driver tasks: wait for in_ready (bounded), present one op for one accept edge.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp);
    int n = 0;
    while (!in_ready32 && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready32) check("dut32 in_ready timeout", 64'd0, 64'd1);
    a32 = a; b32 = b; is_signed32 = s; in_valid32 = 1'b1;
    exp32_q.push_back(exp);
    @(posedge clk); #1;
    in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; is_signed32 = 1'($urandom_range(0, 1));
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input bit push);
    int n = 0;
    while (!in_ready8 && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready8) check("dut8 in_ready timeout", 64'd0, 64'd1);
    a8 = a; b8 = b; is_signed8 = s; in_valid8 = 1'b1;
    if (push) exp8_q.push_back(exp);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); is_signed8 = 1'($urandom_range(0, 1));
  endtask

  task automatic issue8u(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp);
    int n = 0;
    while (!in_ready8u && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready8u) check("dut8u in_ready timeout", 64'd0, 64'd1);
    a8u = a; b8u = b; is_signed8u = s; in_valid8u = 1'b1;
    exp8u_q.push_back(exp);
    @(posedge clk); #1;
    in_valid8u = 1'b0; a8u = 8'($urandom); b8u = 8'($urandom);
  endtask

  task automatic wait_valid8(input string name);
    int n = 0;
    while (!out_valid8 && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid8) check(name, 64'd0, 64'd1);
  endtask

  initial begin
    int lat;

    // Reset values while rst is held
    #2;
    check("rst out_valid", {63'd0, out_valid8}, 64'd0);
    check("rst busy", {63'd0, busy8}, 64'd0);
    check("rst product", {48'd0, product8}, 64'd0);
    check("rst in_ready", {63'd0, in_ready8}, 64'd0);
    check("rst in_ready32", {63'd0, in_ready32}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("idle in_ready", {63'd0, in_ready8}, 64'd1);

    // Unsigned all-ones at 32 bits, with exact latency
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    lat = 0;
    while (!out_valid32 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("dut32 latency", 64'(lat), 64'd33);
    issue32(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    issue32(32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);

    // Signed corner cases at 8 bits
    issue8(8'h80, 8'h80, 1'b1, 16'h4000, 1);
    issue8(8'hFD, 8'h07, 1'b1, 16'hFFEB, 1);
    issue8(8'hFD, 8'h07, 1'b0, 16'h06EB, 1);
    issue8(8'h7F, 8'h7F, 1'b1, 16'h3F01, 1);
    issue8(8'h00, 8'hFF, 1'b1, 16'h0000, 1);
    issue8(8'h80, 8'h01, 1'b1, 16'hFF80, 1);

    // SIGNED_EN=0 ignores is_signed
    issue8u(8'hFF, 8'h02, 1'b1, 16'h01FE);
    issue8u(8'hFD, 8'h07, 1'b1, 16'h06EB);

    // Backpressure, plus an in_valid pulse during RUN that must be ignored
    while (!in_ready8) begin @(posedge clk); #1; end
    out_ready8 = 1'b0;
    issue8(8'hFD, 8'h07, 1'b1, 16'hFFEB, 1);
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h11; is_signed8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    wait_valid8("dut8 backpressure out_valid timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold out_valid", {63'd0, out_valid8}, 64'd1);
      check("hold product", {48'd0, product8}, 64'hFFEB);
      check("hold in_ready", {63'd0, in_ready8}, 64'd0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("post-pulse in_ready", {63'd0, in_ready8}, 64'd1);
    check("post-pulse out_valid", {63'd0, out_valid8}, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check("no second op busy", {63'd0, busy8}, 64'd0);
    check("no second op out_valid", {63'd0, out_valid8}, 64'd0);
    out_ready8 = 1'b1;

    // Reset in RUN at count==5, released between edges
    issue8(8'h40, 8'h03, 1'b0, 16'h0000, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrun rst out_valid", {63'd0, out_valid8}, 64'd0);
    check("midrun rst busy", {63'd0, busy8}, 64'd0);
    check("midrun rst product", {48'd0, product8}, 64'd0);
    check("midrun rst in_ready", {63'd0, in_ready8}, 64'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    issue8(8'h03, 8'h05, 1'b0, 16'h000F, 1);

    // Drain all scoreboards with a bound
    lat = 0;
    while ((exp32_q.size() + exp8_q.size() + exp8u_q.size()) != 0 && lat < 500) begin
      @(posedge clk); lat++;
    end
    repeat (2) @(posedge clk);
    check("dut32 queue drained", 64'(exp32_q.size()), 64'd0);
    check("dut8 queue drained", 64'(exp8_q.size()), 64'd0);
    check("dut8u queue drained", 64'(exp8u_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
